// File: rtl/tbird_pkg.sv
// Shared types and helpers for the T-Bird tail-light sequencer.
// Holds the mode encoding, the brake step code and the prescaler sizing math.
package tbird_pkg;

    typedef enum logic [1:0] {
        MODE_IDLE  = 2'b00,
        MODE_RIGHT = 2'b01,
        MODE_LEFT  = 2'b10,
        MODE_ERROR = 2'b11
    } mode_e;

    localparam logic [3:0] A_BRAKE = 4'b1100;
    localparam logic [3:0] A_OFF   = 4'b0000;

    function automatic int calc_div(input int clk_hz, input int step_hz);
        return clk_hz / step_hz;
    endfunction

    function automatic int calc_width(input int div);
        return (div <= 2) ? 1 : $clog2(div);
    endfunction

    // Only the two turn modes run the phase sequence or honour the brake.
    function automatic logic is_side(input mode_e m);
        return (m == MODE_LEFT) || (m == MODE_RIGHT);
    endfunction

endpackage

// File: rtl/tbird_if.sv
// Switch inputs and decoder-facing outputs of the T-Bird sequencer.
interface tbird_if;
    logic       left;
    logic       right;
    logic       brake;
    logic       s1;
    logic       s0;
    logic [3:0] a;

    modport master (output left, output right, output brake,
                    input  s1,   input  s0,    input  a);

    modport slave  (input  left, input  right, input  brake,
                    output s1,   output s0,    output a);
endinterface

// File: rtl/step_prescaler.sv
// Divides the board clock down to a one-clock step tick every DIV clocks.
module step_prescaler #(
    parameter int DIV   = 4,
    parameter int WIDTH = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(DIV - 1);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = (count_q == LAST) ? '0 : count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tick = en && (count_q == LAST);

endmodule

// File: rtl/tbird_sequencer.sv
// T-Bird sequencing front end: switch synchronizers, turn-signal mode FSM
// and the registered phase/step code fed to the downstream LED decoder.
module tbird_sequencer
    import tbird_pkg::*;
#(
    parameter int CLK_HZ  = 50_000_000,
    parameter int STEP_HZ = 4
) (
    input  logic clk,
    input  logic rst_n,
    tbird_if.slave bus
);

    localparam int DIV   = calc_div(CLK_HZ, STEP_HZ);
    localparam int CNT_W = calc_width(DIV);

    logic [2:0] sync1_q;
    logic [2:0] sync2_q;
    logic       lq, rq, bq;

    mode_e      mode_q, mode_d;
    logic [1:0] phase_q, phase_d;
    logic       brake_q, brake_d;
    logic [3:0] a_q, a_d;

    logic       mode_change;
    logic       run;
    logic       pre_clr;
    logic       tick;
    logic       side_d;

    assign lq = sync2_q[2];
    assign rq = sync2_q[1];
    assign bq = sync2_q[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= {bus.left, bus.right, bus.brake};
            sync2_q <= sync1_q;
        end
    end

    // brake_q mirrors what a_q shows, so the edge that drops the brake code
    // still holds the prescaler and phase 0 gets its full DIV clocks.
    always_comb begin
        mode_d = MODE_IDLE;
        if (lq && rq) begin
            mode_d = MODE_ERROR;
        end else if (lq) begin
            mode_d = MODE_LEFT;
        end else if (rq) begin
            mode_d = MODE_RIGHT;
        end
        mode_change = (mode_d != mode_q);
        run         = is_side(mode_q) && !brake_q && !bq && !mode_change;
    end

    assign pre_clr = !run;

    step_prescaler #(
        .DIV   (DIV),
        .WIDTH (CNT_W)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (pre_clr),
        .en    (run),
        .tick  (tick)
    );

    always_comb begin
        phase_d = 2'b00;
        if (run) begin
            phase_d = tick ? phase_q + 2'd1 : phase_q;
        end
        side_d  = is_side(mode_d);
        brake_d = side_d && bq;
        a_d     = A_OFF;
        if (brake_d) begin
            a_d = A_BRAKE;
        end else if (side_d) begin
            a_d = {2'b00, phase_d};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q  <= MODE_IDLE;
            phase_q <= 2'b00;
            brake_q <= 1'b0;
            a_q     <= A_OFF;
        end else begin
            mode_q  <= mode_d;
            phase_q <= phase_d;
            brake_q <= brake_d;
            a_q     <= a_d;
        end
    end

    assign bus.s1 = mode_q[1];
    assign bus.s0 = mode_q[0];
    assign bus.a  = a_q;

endmodule

// File: tb/tb_tbird_sequencer.sv
// Random and directed bench for tbird_sequencer against an elapsed-time
// model of the turn-signal rules (CLK_HZ = 8, STEP_HZ = 2, so DIV = 4).
module tb_tbird_sequencer;

    localparam int DIV = 4;

    logic clk;
    logic rst_n;

    tbird_if bus ();

    tbird_sequencer #(
        .CLK_HZ  (8),
        .STEP_HZ (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors;
    int miscompares;

    logic [2:0]  in_hist[$];
    logic [1:0]  m_mode;
    bit          m_prev_active;
    int unsigned m_t;
    logic [5:0]  m_exp;

    task automatic checkOutput(input string tag, input logic [5:0] observed,
                               input logic [5:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got s1s0/a=%b/%b, expected %b/%b at %0t",
                     tag, observed[5:4], observed[3:0],
                     expected[5:4], expected[3:0], $time);
        end
    endtask

    task automatic modelReset();
        in_hist.delete();
        in_hist.push_back(3'b000);
        in_hist.push_back(3'b000);
        m_mode        = 2'b00;
        m_prev_active = 1'b0;
        m_t           = 0;
        m_exp         = 6'b0;
    endtask

    // Inputs reach the mode logic two edges late; m_t counts clocks the
    // current side has been running unbraked, and the phase is m_t / DIV.
    task automatic modelEdge();
        logic [2:0] eff;
        logic [1:0] new_mode;
        bit         side, active;
        eff = in_hist.pop_front();
        in_hist.push_back({bus.left, bus.right, bus.brake});
        if (eff[2] && eff[1])  new_mode = 2'b11;
        else if (eff[2])       new_mode = 2'b10;
        else if (eff[1])       new_mode = 2'b01;
        else                   new_mode = 2'b00;
        side   = (new_mode == 2'b10) || (new_mode == 2'b01);
        active = side && !eff[0];
        if (new_mode == m_mode && active && m_prev_active) m_t++;
        else                                              m_t = 0;
        m_mode        = new_mode;
        m_prev_active = active;
        if (!side)       m_exp = {new_mode, 4'b0000};
        else if (eff[0]) m_exp = {new_mode, 4'b1100};
        else             m_exp = {new_mode, 2'b00, 2'((m_t / DIV) % 4)};
    endtask

    task automatic applyStimulus(input logic l, input logic r, input logic b);
        bus.left  = l;
        bus.right = r;
        bus.brake = b;
    endtask

    task automatic runCycles(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            modelEdge();
            @(negedge clk);
            checkOutput(tag, {bus.s1, bus.s0, bus.a}, m_exp);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0);
        modelReset();
        #2;
        checkOutput("reset", {bus.s1, bus.s0, bus.a}, 6'b00_0000);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        runCycles(4, "idle");

        applyStimulus(1'b1, 1'b0, 1'b0);
        runCycles(23, "left_seq");
        applyStimulus(1'b0, 1'b0, 1'b0);
        runCycles(6, "left_off");
        applyStimulus(1'b0, 1'b1, 1'b0);
        runCycles(23, "right_seq");
        applyStimulus(1'b0, 1'b0, 1'b0);
        runCycles(6, "right_off");

        applyStimulus(1'b1, 1'b0, 1'b0);
        runCycles(11, "brake_pre");
        applyStimulus(1'b1, 1'b0, 1'b1);
        runCycles(10, "brake_on");
        applyStimulus(1'b1, 1'b0, 1'b0);
        runCycles(10, "brake_off");
        applyStimulus(1'b0, 1'b0, 1'b0);
        runCycles(6, "brake_idle");

        applyStimulus(1'b1, 1'b1, 1'b0);
        runCycles(6, "error");
        applyStimulus(1'b1, 1'b1, 1'b1);
        runCycles(5, "error_brake");
        applyStimulus(1'b1, 1'b0, 1'b0);
        runCycles(8, "error_exit");

        // Right arrives on the same edge as the second tick of the left run.
        applyStimulus(1'b0, 1'b0, 1'b0);
        runCycles(6, "switch_idle");
        applyStimulus(1'b1, 1'b0, 1'b0);
        runCycles(8, "switch_left");
        applyStimulus(1'b0, 1'b1, 1'b0);
        runCycles(2, "switch_lag");
        runCycles(1, "collision");
        checkOutput("collision_code", {bus.s1, bus.s0, bus.a}, 6'b01_0000);
        runCycles(6, "switch_right");

        applyStimulus(1'b0, 1'b0, 1'b0);
        runCycles(6, "rst_idle");
        applyStimulus(1'b1, 1'b0, 1'b0);
        runCycles(11, "rst_left");
        checkOutput("rst_phase2", {bus.s1, bus.s0, bus.a}, 6'b10_0010);
        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0);
        #1;
        checkOutput("async_reset", {bus.s1, bus.s0, bus.a}, 6'b00_0000);
        modelReset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        runCycles(6, "post_reset");

        for (int seg = 0; seg < 60; seg++) begin
            applyStimulus(1'($urandom % 2), 1'($urandom % 2),
                          1'(($urandom % 4) == 0));
            runCycles(int'($urandom_range(1, 16)), "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
